// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Oversampling UART receiver with majority-vote bit decisions,
//            optional parity, and a first-word-fall-through receive FIFO with
//            RTS flow control and a sticky overrun flag.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int W         = 8,
    parameter int OVS       = 16,
    parameter int PARITY    = 0,
    parameter int DEPTH     = 4,
    parameter int RTS_SLACK = 1
) (
    input  logic         uart_clock,
    input  logic         reset,
    input  logic         rx,
    output logic         rts,
    output logic [W-1:0] out,
    output logic         frame_err,
    output logic         parity_err,
    output logic         valid,
    input  logic         get,
    output logic         overrun
);

    localparam int PW = $clog2(OVS);
    localparam int BW = $clog2(W);
    localparam int AW = $clog2(DEPTH);

    localparam logic [PW-1:0] C_PH_S0    = PW'(OVS/2 - 1);
    localparam logic [PW-1:0] C_PH_S1    = PW'(OVS/2);
    localparam logic [PW-1:0] C_PH_VOTE  = PW'(OVS/2 + 1);
    localparam logic [PW-1:0] C_PH_LAST  = PW'(OVS - 1);
    localparam logic [BW-1:0] C_LAST_BIT = BW'(W - 1);
    localparam logic [AW:0]   C_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_SLACK    = (AW+1)'(RTS_SLACK);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4,
        S_BREAK = 3'd5
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [PW-1:0]   r_phase;
    logic [BW-1:0]   r_bit_idx;
    logic            r_samp0;
    logic            r_samp1;
    logic [W-1:0]    r_data;
    logic            r_perr;

    logic            w_rs;
    logic            w_vote;
    logic            w_at_vote;
    logic            w_at_last;
    logic            w_push;

    // Synchronizer idles high so a low line at reset release looks like a new edge
    always_ff @(posedge uart_clock) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rs      = r_sync2;
    assign w_vote    = (r_samp0 & r_samp1) | (r_samp0 & w_rs) | (r_samp1 & w_rs);
    assign w_at_vote = (r_phase == C_PH_VOTE);
    assign w_at_last = (r_phase == C_PH_LAST);
    assign w_push    = (r_state == S_STOP) && w_at_vote;

    always_ff @(posedge uart_clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_bit_idx <= '0;
            r_samp0   <= 1'b1;
            r_samp1   <= 1'b1;
            r_data    <= '0;
            r_perr    <= 1'b0;
        end else begin
            if (r_state != S_IDLE && r_state != S_BREAK) begin
                r_phase <= w_at_last ? '0 : r_phase + 1'b1;
                if (r_phase == C_PH_S0) r_samp0 <= w_rs;
                if (r_phase == C_PH_S1) r_samp1 <= w_rs;
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_rs) begin
                        r_state   <= S_START;
                        r_phase   <= '0;
                        r_bit_idx <= '0;
                        r_perr    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_at_vote && w_vote)
                        r_state <= S_IDLE;
                    else if (w_at_last)
                        r_state <= S_DATA;
                end
                S_DATA: begin
                    // LSB arrives first, so shifting in from the top lands it at bit 0
                    if (w_at_vote)
                        r_data <= {w_vote, r_data[W-1:1]};
                    if (w_at_last) begin
                        if (r_bit_idx == C_LAST_BIT) begin
                            if (PARITY != 0)
                                r_state <= S_PAR;
                            else
                                r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (w_at_vote) begin
                        if (PARITY == 1)
                            r_perr <= ~((^r_data) ^ w_vote);
                        else
                            r_perr <= (^r_data) ^ w_vote;
                    end
                    if (w_at_last)
                        r_state <= S_STOP;
                end
                S_STOP: begin
                    if (w_at_vote) begin
                        if (w_vote)
                            r_state <= S_IDLE;
                        else
                            r_state <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (w_rs)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [W+1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         r_rts;
    logic         r_overrun;

    logic [AW:0]  w_count;
    logic [AW:0]  w_count_next;
    logic         w_full;
    logic         w_pop;
    logic         w_wr_en;
    logic [W+1:0] w_head;

    assign valid        = (r_wr != r_rd);
    assign w_count      = r_wr - r_rd;
    assign w_full       = (w_count == C_DEPTH);
    assign w_pop        = get && valid;
    assign w_wr_en      = w_push && (!w_full || w_pop);
    assign w_count_next = w_count + (AW+1)'(w_wr_en) - (AW+1)'(w_pop);
    assign w_head       = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge uart_clock) begin
        if (w_wr_en)
            r_mem[r_wr[AW-1:0]] <= {r_perr, ~w_vote, r_data};
    end

    always_ff @(posedge uart_clock) begin
        if (reset) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_rts     <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + 1'b1;
            if (w_pop)   r_rd <= r_rd + 1'b1;
            if (w_push && w_full && !w_pop)
                r_overrun <= 1'b1;
            r_rts <= ((C_DEPTH - w_count_next) >= C_SLACK);
        end
    end

    // Head fields are masked while empty so stale memory never shows
    assign out        = valid ? w_head[W-1:0] : '0;
    assign frame_err  = valid ? w_head[W]     : 1'b0;
    assign parity_err = valid ? w_head[W+1]   : 1'b0;
    assign rts        = r_rts;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo (default and even-parity).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int OVS = 16;

    logic       clk;
    logic       reset;
    logic       line;
    logic       sel;
    logic       getreq;

    logic       rx0, rx1, get0, get1;
    logic       rts0, rts1, ferr0, ferr1, perr0, perr1, valid0, valid1, ovr0, ovr1;
    logic [7:0] out0, out1;

    assign rx0  = (sel == 1'b0) ? line : 1'b1;
    assign rx1  = (sel == 1'b1) ? line : 1'b1;
    assign get0 = (sel == 1'b0) && getreq;
    assign get1 = (sel == 1'b1) && getreq;

    uart_rx_fifo dut0 (
        .uart_clock(clk), .reset(reset), .rx(rx0), .rts(rts0), .out(out0),
        .frame_err(ferr0), .parity_err(perr0), .valid(valid0), .get(get0),
        .overrun(ovr0)
    );

    uart_rx_fifo #(.PARITY(2)) dut1 (
        .uart_clock(clk), .reset(reset), .rx(rx1), .rts(rts1), .out(out1),
        .frame_err(ferr1), .parity_err(perr1), .valid(valid1), .get(get1),
        .overrun(ovr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop();
        getreq = 1'b1;
        tick(1);
        getreq = 1'b0;
    endtask

    // One frame; brk holds the line low for brk extra bit times after the stop bit
    task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pb,
                              input logic stop, input int brk, input int idle,
                              input bit pop_at_vote);
        line = 1'b0;
        tick(OVS);
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            tick(OVS);
        end
        if (has_par) begin
            line = pb;
            tick(OVS);
        end
        line = stop;
        if (pop_at_vote) begin
            tick(12);
            getreq = 1'b1;
            tick(1);
            getreq = 1'b0;
            tick(3);
        end else begin
            tick(OVS);
        end
        if (brk > 0) begin
            line = 1'b0;
            tick(brk * OVS);
        end
        line = 1'b1;
        tick(idle);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pb;
        logic       stop;
        logic [7:0] exp_out;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    vec_t       vecs [6];
    logic [8:0] q [$];
    logic       ovr_model;
    logic [7:0] d;
    logic       stop;
    int         brk;
    int         npop;

    initial begin
        vecs[0] = '{8'hA3, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1};

        line   = 1'b1;
        sel    = 1'b0;
        getreq = 1'b0;
        reset  = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);

        check("reset_valid0", valid0, 0);
        check("reset_out0",   out0,   0);
        check("reset_ferr0",  ferr0,  0);
        check("reset_perr0",  perr0,  0);
        check("reset_ovr0",   ovr0,   0);
        check("reset_rts0",   rts0,   1);
        check("reset_valid1", valid1, 0);
        check("reset_rts1",   rts1,   1);
        check("reset_ovr1",   ovr1,   0);

        // 0x55 with exact push latency: vote cycle is 12 clocks into the stop bit
        line = 1'b0;
        tick(OVS);
        for (int i = 0; i < 8; i++) begin
            line = (8'h55 >> i) & 8'h01;
            tick(OVS);
        end
        line = 1'b1;
        tick(12);
        check("lat_before_vote", valid0, 0);
        tick(1);
        check("lat_after_vote", valid0, 1);
        tick(8);
        check("f55_out",  out0,  8'h55);
        check("f55_ferr", ferr0, 0);
        check("f55_perr", perr0, 0);
        pop();
        check("f55_drained", valid0, 0);

        // Short glitch must not push; a real frame right after must still work
        line = 1'b0;
        tick(5);
        line = 1'b1;
        tick(40);
        check("glitch_nopush", valid0, 0);
        send_frame(8'h3A, 0, 0, 1, 0, 4, 0);
        check("post_glitch_out", out0, 8'h3A);
        pop();

        // Line break: one entry with frame_err, then silence until line is high
        send_frame(8'h81, 0, 0, 0, 30, 40, 0);
        check("brk_valid", valid0, 1);
        check("brk_out",   out0,   8'h81);
        check("brk_ferr",  ferr0,  1);
        pop();
        check("brk_single", valid0, 0);

        // Parity table on the even-parity instance
        sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, 1, vecs[i].pb, vecs[i].stop, 0, 4, 0);
            check($sformatf("par%0d_valid", i), valid1, 1);
            check($sformatf("par%0d_out",   i), out1,   vecs[i].exp_out);
            check($sformatf("par%0d_ferr",  i), ferr1,  vecs[i].exp_ferr);
            check($sformatf("par%0d_perr",  i), perr1,  vecs[i].exp_perr);
            pop();
            check($sformatf("par%0d_empty", i), valid1, 0);
        end
        sel = 1'b0;

        // Overflow: fifth frame dropped, rts drops at fourth push
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 0, 0, 1, 0, 4, 0);
            check($sformatf("ovf_rts%0d", i), rts0, (i < 4) ? 1 : 0);
            check($sformatf("ovf_ovr%0d", i), ovr0, (i < 5) ? 0 : 1);
        end
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_drain%0d", i), out0, i);
            pop();
            check($sformatf("ovf_rts_drain%0d", i), rts0, 1);
        end
        check("ovf_empty",  valid0, 0);
        check("ovf_sticky", ovr0,   1);

        // Full FIFO with pop on the push cycle: both happen, no overrun
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("rst_clears_ovr", ovr0, 0);
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 0, 0, 1, 0, 4, 0);
        send_frame(8'h15, 0, 0, 1, 0, 4, 1);
        check("fullpop_ovr", ovr0, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fullpop_out%0d", i), out0, 8'h12 + 8'(i));
            pop();
        end
        check("fullpop_empty", valid0, 0);

        // Empty FIFO with get on the push cycle: push still lands
        send_frame(8'h66, 0, 0, 1, 0, 4, 1);
        check("emptypop_valid", valid0, 1);
        check("emptypop_out",   out0,   8'h66);
        pop();

        // Reset mid-DATA aborts the frame and empties the FIFO
        send_frame(8'h99, 0, 0, 1, 0, 4, 0);
        line = 1'b0;
        tick(OVS);
        for (int i = 0; i < 4; i++) begin
            line = (8'h3C >> i) & 8'h01;
            tick(OVS);
        end
        line  = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("midrst_valid", valid0, 0);
        check("midrst_out",   out0,   0);
        check("midrst_rts",   rts0,   1);
        tick(OVS * 12);
        check("midrst_nopush", valid0, 0);
        send_frame(8'h7E, 0, 0, 1, 0, 4, 0);
        check("midrst_next_out",  out0,  8'h7E);
        check("midrst_next_ferr", ferr0, 0);
        pop();

        // Randomized frames against a queue model
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        q.delete();
        ovr_model = 1'b0;
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            brk  = stop ? 0 : int'($urandom_range(0, 2));
            send_frame(d, 0, 0, stop, brk, 3, 0);
            if (q.size() < 4) q.push_back({~stop, d});
            else ovr_model = 1'b1;
            check($sformatf("rnd%0d_valid", n), valid0, (q.size() != 0));
            check($sformatf("rnd%0d_rts",   n), rts0,   (q.size() < 4));
            check($sformatf("rnd%0d_ovr",   n), ovr0,   ovr_model);
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) begin
                if (q.size() > 0) begin
                    check($sformatf("rnd%0d_out",  n), out0,  q[0][7:0]);
                    check($sformatf("rnd%0d_ferr", n), ferr0, q[0][8]);
                    check($sformatf("rnd%0d_perr", n), perr0, 0);
                    void'(q.pop_front());
                end
                pop();
                check($sformatf("rnd%0d_popvalid", n), valid0, (q.size() != 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
